// File: rtl/hash_checker.sv
// -----------------------------------------------------------------------------
// hash_checker
//
// Checks a stream of candidate hashes against a compact difficulty target and
// reports the first winning nonce of each block.
//
// Pipeline:
//   stage 1 : registers hash, nonce, valid, new-block flag and the target
//   stage 2 : the FSM / output registers, loaded from the unsigned compare of
//             stage 1. A winning hash therefore shows resultValid exactly two
//             cycles after it is presented at validIn.
//
// Ports:
//   clk          in   single clock, rising edge
//   rst          in   synchronous, active-high reset
//   validIn      in   hash / newBlockIn / difficulty valid this cycle
//   newBlockIn   in   this valid hash is nonce 0 of a new block
//   hash         in   [255:0] candidate hash, unsigned
//   difficulty   in   [31:0] compact target {E[7:0], M[23:0]}, sampled on
//                     validIn && newBlockIn
//   resultValid  out  a winning nonce is presented
//   resultReady  in   consumer accepts the result
//   nonceOut     out  [NONCE_BITS-1:0] winning nonce, stable while resultValid
//   exhausted    out  nonce space of the current block used up without a win
//   hashCount    out  [31:0] (only with HASH_CHECKER_STATS_EN) valid hashes
//                     seen since the last new block, saturating
//
// Optional feature macro: HASH_CHECKER_STATS_EN
// -----------------------------------------------------------------------------
module hash_checker #(
  parameter int NONCE_BITS = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  validIn,
  input  logic                  newBlockIn,
  input  logic [255:0]          hash,
  input  logic [31:0]           difficulty,
  output logic                  resultValid,
  input  logic                  resultReady,
  output logic [NONCE_BITS-1:0] nonceOut,
  output logic                  exhausted
`ifdef HASH_CHECKER_STATS_EN
  ,
  output logic [31:0]           hashCount
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    SEARCH,
    FOUND,
    EXHAUSTED
  } state_e;

  // ---------------------------------------------------------------------------
  // Compact target decode
  // ---------------------------------------------------------------------------
  logic [7:0]   diff_exp;
  logic [23:0]  diff_mant;
  logic [255:0] mant_ext;
  logic [10:0]  shl_amt;
  logic [10:0]  shr_amt;
  logic [255:0] target_d;
  logic         target_neg_d;

  assign diff_exp  = difficulty[31:24];
  assign diff_mant = difficulty[23:0];
  assign mant_ext  = {233'd0, diff_mant[22:0]};
  // Byte-granular shift distances; only the one matching the exponent range
  // is used, so the out-of-range one wrapping is harmless.
  assign shl_amt   = {diff_exp - 8'd3, 3'b000};
  assign shr_amt   = {8'd3 - diff_exp, 3'b000};

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    target_d     = '0;
    target_neg_d = 1'b0;
    if (diff_mant[23]) begin
      // Sign bit set: the target is zero and, being negative, nothing can
      // satisfy it -- not even an all-zero hash.
      target_d     = '0;
      target_neg_d = 1'b1;
    end else if (diff_exp > 8'd32) begin
      target_d = (diff_mant[22:0] != 23'd0) ? '1 : '0;
    end else if (diff_exp >= 8'd3) begin
      target_d = mant_ext << shl_amt;
    end else begin
      target_d = mant_ext >> shr_amt;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 1 control, nonce counter and latched block target
  // ---------------------------------------------------------------------------
  logic                  s1_valid_q;
  logic                  s1_new_q;
  logic [NONCE_BITS-1:0] nonce_q;
  logic [255:0]          target_q;
  logic                  target_neg_q;

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      s1_valid_q   <= 1'b0;
      s1_new_q     <= 1'b0;
      nonce_q      <= '0;
      target_q     <= '0;
      target_neg_q <= 1'b0;
    end else begin
      s1_valid_q <= validIn;
      s1_new_q   <= validIn && newBlockIn;
      if (validIn) begin
        if (newBlockIn) begin
          nonce_q      <= NONCE_BITS'(1);
          target_q     <= target_d;
          target_neg_q <= target_neg_d;
        end else begin
          // Wraps to zero past all ones; the FSM already sits in EXHAUSTED.
          nonce_q <= nonce_q + NONCE_BITS'(1);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 1 datapath
  // ---------------------------------------------------------------------------
  logic [255:0]          s1_hash_q;
  logic [NONCE_BITS-1:0] s1_nonce_q;
  logic [255:0]          s1_target_q;
  logic                  s1_neg_q;

  // NOTE: wide datapath registers carry no reset; they are only consumed
  // when the separately reset s1_valid_q says they hold a live hash.
  always_ff @(posedge clk) begin
    if (validIn) begin
      s1_hash_q   <= hash;
      // The new-block hash is nonce 0 and is judged against its own target.
      s1_nonce_q  <= newBlockIn ? '0 : nonce_q;
      s1_target_q <= newBlockIn ? target_d : target_q;
      s1_neg_q    <= newBlockIn ? target_neg_d : target_neg_q;
    end
  end

  logic s1_win;
  assign s1_win = !s1_neg_q && (s1_hash_q <= s1_target_q);

  // ---------------------------------------------------------------------------
  // Stage 2: result FSM with registered outputs
  // ---------------------------------------------------------------------------
  state_e                state_q;
  logic                  result_valid_q;
  logic                  exhausted_q;
  logic [NONCE_BITS-1:0] nonce_out_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      result_valid_q <= 1'b0;
      exhausted_q    <= 1'b0;
      nonce_out_q    <= '0;
    end else if (s1_valid_q && s1_new_q) begin
      // A new block overrides everything, including an unaccepted result
      // that is being acknowledged in this very cycle.
      exhausted_q <= 1'b0;
      if (s1_win) begin
        state_q        <= FOUND;
        result_valid_q <= 1'b1;
        nonce_out_q    <= s1_nonce_q;
      end else begin
        state_q        <= SEARCH;
        result_valid_q <= 1'b0;
      end
    end else begin
      case (state_q)
        SEARCH: begin
          if (s1_valid_q) begin
            if (s1_win) begin
              state_q        <= FOUND;
              result_valid_q <= 1'b1;
              nonce_out_q    <= s1_nonce_q;
            end else if (s1_nonce_q == '1) begin
              state_q     <= EXHAUSTED;
              exhausted_q <= 1'b1;
            end
          end
        end
        FOUND: begin
          if (resultReady) begin
            state_q        <= IDLE;
            result_valid_q <= 1'b0;
          end
        end
        default: begin
          // IDLE and EXHAUSTED ignore hashes of the current block.
        end
      endcase
    end
  end

  assign resultValid = result_valid_q;
  assign exhausted   = exhausted_q;
  assign nonceOut    = nonce_out_q;

  // ---------------------------------------------------------------------------
  // Optional hash statistics
  // ---------------------------------------------------------------------------
`ifdef HASH_CHECKER_STATS_EN
  logic [31:0] hash_count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      hash_count_q <= '0;
    end else if (validIn) begin
      if (newBlockIn) begin
        hash_count_q <= 32'd1;
      end else if (hash_count_q != '1) begin
        hash_count_q <= hash_count_q + 32'd1;
      end
    end
  end

  assign hashCount = hash_count_q;
`endif

endmodule

// File: doc/hash_checker.md
HASH_CHECKER -- requirements
Module: hash_checker

Interface
REQ-001 The block SHALL have parameter NONCE_BITS, default 32, giving the nonce counter width.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port validIn, input, 1 bit: hash/newBlockIn/difficulty are valid this cycle.
REQ-005 The block SHALL have port newBlockIn, input, 1 bit: this valid hash is the first of a new block (nonce 0).
REQ-006 The block SHALL have port hash, input, 256 bits: candidate hash, unsigned, bit 255 MSB.
REQ-007 The block SHALL have port difficulty, input, 32 bits: compact target, [31:24] exponent E, [23:0] mantissa M; sampled only when validIn && newBlockIn.
REQ-008 The block SHALL have port resultValid, output, 1 bit: a winning nonce is presented.
REQ-009 The block SHALL have port resultReady, input, 1 bit: consumer accepts the result.
REQ-010 The block SHALL have port nonceOut, output, NONCE_BITS: the winning nonce, stable while resultValid.
REQ-011 The block SHALL have port exhausted, output, 1 bit: level, the nonce space of the current block was used up without a win.

Function
REQ-012 The block SHALL keep a nonce counter: set to 1 after a valid newBlockIn hash (that hash carries nonce 0), incremented by 1 after every other valid hash, unchanged when validIn=0.
REQ-013 Target SHALL be M[22:0] shifted left 8*(E-3) bits for 3<=E<=32, and shifted right 8*(3-E) bits for E<3.
REQ-014 If M[23]=1 the target SHALL be 0; if E>32 and M[22:0]!=0 the target SHALL be all ones.
REQ-015 The target SHALL be latched on validIn && newBlockIn and used for all hashes of that block, including the newBlockIn hash itself.
REQ-016 Pipeline stage 1 SHALL register hash, nonce, valid, new and the target; stage 2 SHALL register the unsigned compare hash <= target.
REQ-017 The latency from a winning hash at validIn to resultValid=1 SHALL be exactly 2 cycles.
REQ-018 The FSM SHALL have the states IDLE, SEARCH, FOUND and EXHAUSTED, with IDLE as the reset state.
REQ-019 Any state SHALL go to SEARCH when a stage-2 new-block hash does not win, and to FOUND when it wins.
REQ-020 In SEARCH, a winning stage-2 hash SHALL go to FOUND and capture nonceOut; a losing hash with nonce = all ones SHALL go to EXHAUSTED.
REQ-021 In FOUND, resultValid SHALL be 1; resultReady=1 SHALL go to IDLE on the next edge; further hashes of the same block SHALL be ignored.
REQ-022 In EXHAUSTED, exhausted SHALL be 1 and non-new hashes SHALL be ignored.
REQ-023 In IDLE, non-new hashes SHALL be ignored.
REQ-024 A new-block hash reaching stage 2 while in FOUND SHALL drop the unaccepted result, even if resultReady is 1 in the same cycle.
REQ-025 The nonce counter SHALL wrap to 0 at all ones; that wrap SHALL NOT itself produce a result.
REQ-026 resultValid and exhausted SHALL never be 1 at the same time.

Reset
REQ-027 On rst=1 at a clock edge the block SHALL set: state IDLE, resultValid=0, exhausted=0, nonceOut=0, nonce counter=0, latched target=0, all pipeline valid/new bits=0.
REQ-028 rst SHALL take priority over every other input in the same cycle, and an in-flight hash SHALL be discarded.

Configuration
REQ-029 With macro HASH_CHECKER_STATS_EN defined, the block SHALL add output hashCount, 32 bits: valid hashes checked since the last new block, counting that block's newBlockIn hash as 1, saturating at all ones, reset to 0.
REQ-030 Without HASH_CHECKER_STATS_EN, the hashCount port and its logic SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-031 The bench SHALL cover: difficulty=0x1D00FFFF, newBlockIn hash nonce 0 = 0xFF..FF, then nonce 1 hash = 0x00000000FFFF0000..0 -> resultValid=1 two cycles after nonce 1, nonceOut=1, held until resultReady=1, then IDLE.
REQ-032 The bench SHALL cover: difficulty=0x20800000 (M[23]=1), any hashes -> no resultValid ever, even for hash=0.
REQ-033 The bench SHALL cover: NONCE_BITS=4, 16 losing hashes -> exhausted=1 after the 16th; a subsequent newBlockIn clears it.
REQ-034 The bench SHALL cover: winning hash, resultReady=0, then newBlockIn with a losing hash -> resultValid drops, state SEARCH, nonce counter restarts.
REQ-035 The bench SHALL cover: rst=1 asserted one cycle after a winning hash enters -> no resultValid, all outputs 0.
REQ-036 The bench SHALL cover: validIn toggled 1,0,0,1 within a block -> nonces 0 and 1 only, and hashCount=2 with HASH_CHECKER_STATS_EN defined.
